// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : constants and state encoding shared by the UART send/recv blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 128;
  localparam int CLK_FREQ    = 50_000_000;
  localparam int UART_BPS    = 115_200;

  typedef logic [1:0] arb_state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational winner select, round robin after 'last' by default,
//           lowest index first when UART_ARB_FIXED_PRIO_EN is defined
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

`ifndef UART_ARB_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % N_REQ);
  endfunction
`else
  logic unused_last;
  assign unused_last = ^last;
`endif

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
`else
    // Scan from the farthest offset down so the nearest pending requester wins.
    for (int off = N_REQ; off >= 1; off--) begin
      if (req[rot(last, off)]) begin
        valid = 1'b1;
        idx   = rot(last, off);
      end
    end
`endif
    onehot[idx] = valid;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter : shares p_uart_send between N_REQ requesters
//                   (define UART_ARB_FIXED_PRIO_EN for fixed priority)
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = UART_DATA_W,
  parameter int START_TO = 16,
  parameter int GAP_CYC  = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic [idx_w(N_REQ)-1:0] grant_id,
  output logic                    uart_en,
  output logic [DATA_W-1:0]       uart_din,
  input  logic                    uart_tx_busy
);

  localparam int GW  = idx_w(N_REQ);
  localparam int TW  = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam int GPW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  arb_state_t        state_q, state_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [TW-1:0]     to_q, to_d;
  logic [GPW-1:0]    gap_q, gap_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [GW-1:0]     gid_q, gid_d;

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_onehot;
  logic [GW-1:0]     pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (GW)
  ) u_pick (
    .req    (req),
    .last   (rr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    to_d    = to_q;
    gap_d   = gap_q;
    din_d   = din_q;
    gid_d   = gid_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (pick_valid && !uart_tx_busy) begin
          din_d   = req_data[pick_idx*DATA_W +: DATA_W];
          gid_d   = pick_idx;
          ack_d   = pick_onehot;
          rr_d    = pick_idx;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        en_d    = 1'b1;
        to_d    = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_q == TW'(START_TO - 1)) begin
          // Transmitter never accepted the frame; drop it, the owner must re-request.
          err_d[gid_q] = 1'b1;
          gap_d        = GPW'(GAP_CYC);
          state_d      = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          done_d[gid_q] = 1'b1;
          gap_d         = GPW'(GAP_CYC);
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= GW'(N_REQ - 1);
      to_q    <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      din_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      din_q   <= din_d;
      gid_q   <= gid_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign grant_id = gid_q;
  assign uart_en  = en_q;
  assign uart_din = din_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter : randomized self-checking bench with a transmitter model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int DW  = 128;
  localparam int STO = 16;
  localparam int GAP = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack, done, err;
  logic [0:0]      grant_id;
  logic            uart_en;
  logic [DW-1:0]   uart_din;
  logic            uart_tx_busy;

  bit   tx_auto = 1'b0;
  logic busy_force = 1'b0;
  logic busy_model = 1'b0;
  int   tx_delay = 3, tx_len = 100;
  int   rise_in = 0, hold = 0, fall_cyc = -1;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   model_last = N - 1;

  assign uart_tx_busy = tx_auto ? busy_model : busy_force;

  uart_tx_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .START_TO (STO),
    .GAP_CYC  (GAP)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .done         (done),
    .err          (err),
    .grant_id     (grant_id),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transmitter model: busy rises tx_delay cycles after uart_en, stays tx_len cycles.
  always @(negedge clk) begin
    if (!tx_auto) begin
      rise_in    = 0;
      hold       = 0;
      busy_model = 1'b0;
    end else if (uart_en) begin
      rise_in = tx_delay;
    end else if (rise_in > 0) begin
      rise_in--;
      if (rise_in == 0) begin
        busy_model = 1'b1;
        hold       = tx_len;
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) begin
        busy_model = 1'b0;
        fall_cyc   = cyc;
      end
    end
  end

  function automatic int model_pick(input logic [N-1:0] pend, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // which: 0 ack, 1 done, 2 err, 3 uart_en. dd counts done/err cycles seen meanwhile.
  task automatic wait_for(input int which, input int budget, output int at, output bit ok,
                          output int dd);
    ok = 1'b0; at = -1; dd = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      case (which)
        0:       ok = |ack;
        1:       ok = |done;
        2:       ok = |err;
        default: ok = uart_en;
      endcase
      if (ok) at = cyc;
      else if (|done || |err) dd++;
    end
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    #1;
    repeat (2) @(negedge clk);
    n_checks++; if (ack !== '0)      begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_checks++; if (done !== '0)     begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (err !== '0)      begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if (uart_en !== 1'b0) begin n_fail++; $display("FAIL rst_en: got %b want 0", uart_en); end
    n_checks++; if (uart_din !== '0) begin n_fail++; $display("FAIL rst_din: got %h want 0", uart_din); end
    n_checks++; if (grant_id !== '0) begin n_fail++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  task automatic test_single();
    logic [DW-1:0] d0;
    int c0, at, dd, ex;
    bit ok;
    d0 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    tx_auto = 1'b1; tx_delay = 3; tx_len = 100;
    @(negedge clk);
    req_data[0 +: DW] = d0;
    req = 2'b01;
    c0 = cyc;
    wait_for(0, 10, at, ok, dd);
    ex = model_pick(req, model_last);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_ack_seen: got none want ack"); end
    n_checks++; if (at != c0 + 1) begin n_fail++; $display("FAIL single_ack_lat: got %0d want %0d", at - c0, 1); end
    n_checks++; if (ack !== oh(ex)) begin n_fail++; $display("FAIL single_ack: got %b want %b", ack, oh(ex)); end
    req = '0;
    model_last = ex;
    @(negedge clk);
    n_checks++; if (uart_en !== 1'b1) begin n_fail++; $display("FAIL single_en: got %b want 1", uart_en); end
    n_checks++; if (uart_din !== d0) begin n_fail++; $display("FAIL single_din: got %h want %h", uart_din, d0); end
    n_checks++; if (grant_id !== ex[0:0]) begin n_fail++; $display("FAIL single_gid: got %0d want %0d", grant_id, ex); end
    @(negedge clk);
    n_checks++; if (uart_en !== 1'b0) begin n_fail++; $display("FAIL single_en_pulse: got %b want 0", uart_en); end
    wait_for(1, 200, at, ok, dd);
    n_checks++; if (done !== oh(ex)) begin n_fail++; $display("FAIL single_done: got %b want %b", done, oh(ex)); end
    n_checks++; if (at != fall_cyc + 1) begin n_fail++; $display("FAIL single_done_lat: got %0d want %0d", at, fall_cyc + 1); end
    n_checks++; if (uart_din !== d0) begin n_fail++; $display("FAIL single_din_hold: got %h want %h", uart_din, d0); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] want;
    int at, dd, ex, prev_done;
    bit ok;
    tx_auto = 1'b1; tx_delay = 1; tx_len = 4;
    prev_done = -1;
    @(negedge clk);
    req_data[0 +: DW]  = rnd128();
    req_data[DW +: DW] = rnd128();
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_for(0, 60, at, ok, dd);
      ex   = model_pick(req, model_last);
      want = req_data[ex*DW +: DW];
      n_checks++; if (ack !== oh(ex)) begin n_fail++; $display("FAIL rr_ack%0d: got %b want %b", f, ack, oh(ex)); end
      if (prev_done >= 0) begin
        n_checks++;
        if (at - prev_done != GAP + 1) begin
          n_fail++; $display("FAIL rr_gap%0d: got %0d want %0d", f, at - prev_done, GAP + 1);
        end
      end
      model_last = ex;
      if (f == 3) req = '0;
      else req_data[ex*DW +: DW] = rnd128();
      @(negedge clk);
      n_checks++; if (uart_din !== want) begin n_fail++; $display("FAIL rr_din%0d: got %h want %h", f, uart_din, want); end
      wait_for(1, 60, at, ok, dd);
      n_checks++; if (done !== oh(ex)) begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", f, done, oh(ex)); end
      prev_done = at;
    end
  endtask

  task automatic test_timeout();
    int at, dd, ex, en_cyc, err_at;
    bit ok;
    tx_auto = 1'b0; busy_force = 1'b0;
    repeat (GAP + 2) @(negedge clk);
    req_data[0 +: DW] = rnd128();
    req = 2'b01;
    wait_for(0, 10, at, ok, dd);
    ex = model_pick(req, model_last);
    n_checks++; if (ack !== oh(ex)) begin n_fail++; $display("FAIL to_ack: got %b want %b", ack, oh(ex)); end
    req = '0;
    model_last = ex;
    en_cyc = at + 1;
    wait_for(2, 40, at, ok, dd);
    n_checks++; if (err !== oh(ex)) begin n_fail++; $display("FAIL to_err: got %b want %b", err, oh(ex)); end
    n_checks++; if (at != en_cyc + STO) begin n_fail++; $display("FAIL to_err_lat: got %0d want %0d", at - en_cyc, STO); end
    n_checks++; if (dd != 0) begin n_fail++; $display("FAIL to_no_done: got %0d want 0", dd); end
    err_at = at;
    req_data[DW +: DW] = rnd128();
    req = 2'b10;
    wait_for(0, 20, at, ok, dd);
    ex = model_pick(req, model_last);
    n_checks++; if (ack !== oh(ex)) begin n_fail++; $display("FAIL to_next_ack: got %b want %b", ack, oh(ex)); end
    n_checks++; if (at != err_at + GAP + 1) begin n_fail++; $display("FAIL to_next_lat: got %0d want %0d", at - err_at, GAP + 1); end
    req = '0;
    model_last = ex;
    wait_for(2, 40, at, ok, dd);
    n_checks++; if (err !== oh(ex)) begin n_fail++; $display("FAIL to_err2: got %b want %b", err, oh(ex)); end
  endtask

  task automatic test_busy_stall();
    int at, dd, ex, c, n_bad;
    bit ok;
    busy_force = 1'b1;
    repeat (GAP + 2) @(negedge clk);
    req_data[DW +: DW] = rnd128();
    req = 2'b10;
    n_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (|ack || uart_en) n_bad++;
    end
    n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL stall_quiet: got %0d launches want 0", n_bad); end
    busy_force = 1'b0;
    c = cyc;
    wait_for(0, 5, at, ok, dd);
    ex = model_pick(req, model_last);
    n_checks++; if (at != c + 1) begin n_fail++; $display("FAIL stall_ack_lat: got %0d want %0d", at - c, 1); end
    n_checks++; if (ack !== oh(ex)) begin n_fail++; $display("FAIL stall_ack: got %b want %b", ack, oh(ex)); end
    req = '0;
    model_last = ex;
    @(negedge clk);
    n_checks++; if (uart_en !== 1'b1) begin n_fail++; $display("FAIL stall_en: got %b want 1", uart_en); end
    busy_force = 1'b1;
    repeat (3) @(negedge clk);
    busy_force = 1'b0;
    c = cyc;
    wait_for(1, 5, at, ok, dd);
    n_checks++; if (done !== oh(ex)) begin n_fail++; $display("FAIL stall_done: got %b want %b", done, oh(ex)); end
    n_checks++; if (at != c + 1) begin n_fail++; $display("FAIL stall_done_lat: got %0d want %0d", at - c, 1); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] want;
    int at, dd, ex, c;
    bit ok;
    busy_force = 1'b0;
    repeat (GAP + 2) @(negedge clk);
    req_data[DW +: DW] = rnd128() | 128'h1;
    req = 2'b10;
    wait_for(0, 10, at, ok, dd);
    model_last = model_pick(req, model_last);
    req_data[0 +: DW]  = rnd128();
    req_data[DW +: DW] = rnd128();
    req = 2'b11;
    @(negedge clk);
    busy_force = 1'b1;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (uart_din !== '0) begin n_fail++; $display("FAIL mid_rst_din: got %h want 0", uart_din); end
    n_checks++; if (grant_id !== '0) begin n_fail++; $display("FAIL mid_rst_gid: got %0d want 0", grant_id); end
    n_checks++; if ({ack, done, err, uart_en} !== '0) begin
      n_fail++; $display("FAIL mid_rst_pulses: got %b want 0", {ack, done, err, uart_en});
    end
    busy_force = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    c = cyc;
    wait_for(0, 5, at, ok, dd);
    ex   = model_pick(req, model_last);
    want = req_data[ex*DW +: DW];
    n_checks++; if (dd != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", dd); end
    n_checks++; if (at != c + 1) begin n_fail++; $display("FAIL mid_ack_lat: got %0d want %0d", at - c, 1); end
    n_checks++; if (ack !== oh(ex)) begin n_fail++; $display("FAIL mid_ack: got %b want %b", ack, oh(ex)); end
    n_checks++; if (uart_din !== want) begin n_fail++; $display("FAIL mid_din: got %h want %h", uart_din, want); end
    req = '0;
    model_last = ex;
    @(negedge clk);
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    busy_force = 1'b0;
    wait_for(1, 5, at, ok, dd);
    n_checks++; if (done !== oh(ex)) begin n_fail++; $display("FAIL mid_done: got %b want %b", done, oh(ex)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_stall();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
